// File: rtl/shift_add_mult8.sv
// shift_add_mult8 -- sequential 8x8 unsigned multiplier.
//   One 16-bit carry-select adder (csa16) is shared across cycles. Each RUN
//   cycle it adds the shifted multiplicand into the running partial sum when
//   the current multiplier LSB is set. The product is registered on entry to
//   DONE and held until the next accepted start.
//
//   Optional build macro: MULT_EARLY_DONE_EN
//     defined   -> RUN also ends once the remaining multiplier bits are zero
//     undefined -> always exactly 8 add cycles
//
// Ports
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   start  in   1   multiply request, sampled only in IDLE
//   A      in   8   multiplicand, sampled on the accepting edge
//   B      in   8   multiplier, sampled on the accepting edge
//   busy   out  1   high in RUN and DONE
//   done   out  1   one-cycle pulse while in DONE
//   P      out  16  product, held until the next accepted start

module csa16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  // Upper byte is computed for both possible carries and selected by the
  // carry out of the lower byte.
  assign lo  = {1'b0, a[7:0]}  + {1'b0, b[7:0]} + {8'h00, cin};
  assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  assign s    = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
  assign cout = lo[8] ? hi1[8] : hi0[8];
endmodule

module shift_add_mult8 #(
  parameter int N_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] P
);
  // The shared adder is 16 bits wide, so only 8-bit operands are supported.
  generate
    if (N_BITS != 8) begin : g_bad_width
      $error("shift_add_mult8: N_BITS must be 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] acc_q;
  logic [15:0] mcand_q;
  logic [7:0]  mplier_q;
  logic [3:0]  cnt_q;
  logic [15:0] p_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] addend_d;
  logic [15:0] sum_d;
  logic        last_add_d;

  assign addend_d = mplier_q[0] ? mcand_q : 16'h0000;

  // Carry out can never be set: the product fits in 16 bits.
  csa16 u_csa16 (
    .a    (acc_q),
    .b    (addend_d),
    .cin  (1'b0),
    .s    (sum_d),
    .cout ()
  );

`ifdef MULT_EARLY_DONE_EN
  // Stop as soon as no multiplier bits remain after this add.
  assign last_add_d = (cnt_q == 4'd7) || (mplier_q[7:1] == 7'd0);
`else
  assign last_add_d = (cnt_q == 4'd7);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 8'h00;
      cnt_q    <= 4'd0;
      p_q      <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q  <= {8'h00, A};
            mplier_q <= B;
            acc_q    <= 16'h0000;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q    <= sum_d;
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[7:1]};
          cnt_q    <= cnt_q + 4'd1;
          if (last_add_d) begin
            p_q     <= sum_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;
endmodule
